// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period helper and
// framing constants. Used by the transmitter and by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // Clock cycles per serial bit, integer-truncated.
  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter.
//   clk, rst     : clock, synchronous active-high reset
//   restart      : holds the counter at 0 (period starts on the first cycle
//                  after restart drops)
//   half         : use a half bit period (mid-bit sampling in a receiver)
//   count        : cycle index within the current period
//   bit_done     : one-cycle pulse on the last cycle of each period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        half,
  output logic [15:0] count,
  output logic        bit_done
);

  localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic [15:0] last;

  assign last = half ? HALF_LAST : FULL_LAST;
  // >= so that switching to the half period mid-count still terminates.
  assign bit_done = !restart && (count >= last);

  always_ff @(posedge clk) begin
    if (rst || restart)     count <= '0;
    else if (count >= last) count <= '0;
    else                    count <= count + 16'd1;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per valid/ready handshake, serialised as
// start bit, 8 data bits LSB-first, optional parity bit, 1 or 2 stop bits.
//   clk, rst      : clock, synchronous active-high reset
//   enable        : gates acceptance of new frames only
//   tx_data       : byte, latched on handshake
//   tx_valid      : tx_data valid
//   tx_ready      : idle and enabled (combinational)
//   Tx            : registered serial line, idle high
//   busy          : frame in flight
//   bits_sent     : index of the bit on Tx (0 start, 1..8 data, 9 parity, then stop)
//   BAUD_counter  : cycle index within the current bit
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        Tx,
  output logic        busy,
  output logic [3:0]  bits_sent,
  output logic [15:0] BAUD_counter
);

  localparam int CPB = clks_per_bit(CLOCK_FREQ, BAUD_RATE);

  if (CPB < 2 || CPB > 65535) begin : g_bad_cpb
    $error("uart_transmitter: CLOCK_FREQ/BAUD_RATE must be in 2..65535");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_transmitter: STOP_BITS must be 1 or 2");
  end

  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic [3:0]  bits_q, bits_d;
  logic        stop_q, stop_d;
  logic        bit_done;
  logic        xfer;

  uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (state_q == IDLE),
    .half     (1'b0),
    .count    (BAUD_counter),
    .bit_done (bit_done)
  );

  // rst is folded in so ready stays low while reset is held.
  assign tx_ready  = (state_q == IDLE) && enable && !rst;
  assign xfer      = tx_valid && tx_ready;
  assign Tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign bits_sent = bits_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= IDLE_LEVEL;
      bits_q  <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      bits_q  <= bits_d;
      stop_q  <= stop_d;
    end
  end

  // Tx is registered, so each transition loads the level of the bit that
  // the next state will present.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    bits_d  = bits_q;
    stop_d  = stop_q;
    unique case (state_q)
      IDLE: begin
        tx_d   = IDLE_LEVEL;
        bits_d = '0;
        if (xfer) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ 1'(PARITY_ODD);
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          tx_d    = shift_q[0];
          bits_d  = bits_q + 4'd1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          bits_d  = bits_q + 4'd1;
          if (bits_q == 4'(DATA_BITS)) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = IDLE_LEVEL;
              stop_d  = 1'b0;
              state_d = STOP;
            end
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          tx_d    = IDLE_LEVEL;
          bits_d  = bits_q + 4'd1;
          stop_d  = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          tx_d = IDLE_LEVEL;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            bits_d  = '0;
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
            bits_d = bits_q + 4'd1;
          end
        end
      end
      default: begin
        tx_d    = IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase
  end

endmodule
